hazard_scoreboard: RTL and testbench

Register-write scoreboard for the in-order RISC-V pipeline, sitting beside decode. It records which architectural registers have an in-flight producer and when that producer's value becomes forwardable, and tells decode to stall until then. The forwarding network then delivers the value, so the scoreboard stalls only when no forwarding path can supply the operand yet. It also enforces one in-flight writer per register (WAW stall).

---
 rtl/riscv_pipeline_pkg.sv | 16 +
 rtl/scoreboard_entry.sv | 92 +++++++++
 rtl/hazard_scoreboard.sv | 71 +++++++
 tb/tb_hazard_scoreboard.sv | 392 +++++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/riscv_pipeline_pkg.sv
// Shared pipeline types and sizing constants for the in-order RISC-V core.
// Producer classes and register-number widths used by the hazard scoreboard.
package riscv_pipeline_pkg;

    typedef enum logic [1:0] {
        OpAlu      = 2'd0,
        OpLoad     = 2'd1,
        OpLong     = 2'd2,
        OpReserved = 2'd3
    } op_class_t;

    localparam int unsigned DEFAULT_REGISTER_COUNT = 32;
    localparam int unsigned REGISTER_NUMBER_WIDTH  = 5;
    localparam int unsigned DELAY_WIDTH            = 2;

endpackage

// File: rtl/scoreboard_entry.sv
// State for one architectural register: pending bit, forwarding delay and optional long_wait.
// Optional feature macro: SCOREBOARD_LONG_OP_EN (adds long_wait and long_complete).
module scoreboard_entry
    import riscv_pipeline_pkg::*;
#(
    parameter int unsigned LOAD_DELAY = 1
) (
    input  logic      clock,
    input  logic      reset,
    input  logic      issue,
    input  op_class_t issue_op_class,
    input  logic      write_back,
    input  logic      squash,
`ifdef SCOREBOARD_LONG_OP_EN
    input  logic      long_complete,
`endif
    output logic      pending,
    output logic      not_ready
);

    localparam logic [DELAY_WIDTH-1:0] LoadDelay = DELAY_WIDTH'(LOAD_DELAY);

    logic                   pending_q, pending_d;
    logic [DELAY_WIDTH-1:0] delay_q, delay_d;
`ifdef SCOREBOARD_LONG_OP_EN
    logic                   long_wait_q, long_wait_d;
`endif

    // Later assignments win: squash > issue > write back > long_complete > decrement.
    always_comb begin
        pending_d = pending_q;
        delay_d   = (delay_q != '0) ? delay_q - DELAY_WIDTH'(1) : delay_q;
`ifdef SCOREBOARD_LONG_OP_EN
        long_wait_d = long_wait_q;
        if (long_complete) long_wait_d = 1'b0;
`endif
        if (write_back) begin
            pending_d = 1'b0;
            delay_d   = '0;
`ifdef SCOREBOARD_LONG_OP_EN
            long_wait_d = 1'b0;
`endif
        end
        if (issue) begin
            pending_d = 1'b1;
            delay_d   = '0;
`ifdef SCOREBOARD_LONG_OP_EN
            long_wait_d = 1'b0;
`endif
            case (issue_op_class)
                OpLoad: delay_d = LoadDelay;
`ifdef SCOREBOARD_LONG_OP_EN
                OpLong: long_wait_d = 1'b1;
`else
                OpLong: delay_d = LoadDelay;
`endif
                default: ;
            endcase
        end
        if (squash) begin
            pending_d = 1'b0;
            delay_d   = '0;
`ifdef SCOREBOARD_LONG_OP_EN
            long_wait_d = 1'b0;
`endif
        end
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            pending_q <= 1'b0;
            delay_q   <= '0;
`ifdef SCOREBOARD_LONG_OP_EN
            long_wait_q <= 1'b0;
`endif
        end else begin
            pending_q <= pending_d;
            delay_q   <= delay_d;
`ifdef SCOREBOARD_LONG_OP_EN
            long_wait_q <= long_wait_d;
`endif
        end
    end

    assign pending = pending_q;
`ifdef SCOREBOARD_LONG_OP_EN
    assign not_ready = pending_q & ((delay_q != '0) | long_wait_q);
`else
    assign not_ready = pending_q & (delay_q != '0);
`endif

endmodule

// File: rtl/hazard_scoreboard.sv
// Register-write scoreboard beside decode: tracks in-flight producers, raises operand and WAW stalls.
// Optional feature macro: SCOREBOARD_LONG_OP_EN (LONG producers wait for long_complete).
module hazard_scoreboard
    import riscv_pipeline_pkg::*;
#(
    parameter int unsigned REGISTER_COUNT = riscv_pipeline_pkg::DEFAULT_REGISTER_COUNT,
    parameter int unsigned LOAD_DELAY     = 1
) (
    input  logic                             clock,
    input  logic                             reset,
    input  logic                             issue_valid,
    input  logic                             issue_write_enable,
    input  logic [REGISTER_NUMBER_WIDTH-1:0] issue_destination_register_number,
    input  op_class_t                        issue_op_class,
    input  logic [REGISTER_NUMBER_WIDTH-1:0] register_number_a,
    input  logic [REGISTER_NUMBER_WIDTH-1:0] register_number_b,
    input  logic [REGISTER_NUMBER_WIDTH-1:0] decode_destination_register_number,
    input  logic                             decode_write_enable,
    input  logic                             write_back_valid,
    input  logic [REGISTER_NUMBER_WIDTH-1:0] write_back_destination_register_number,
    input  logic                             squash_valid,
    input  logic [REGISTER_NUMBER_WIDTH-1:0] squash_destination_register_number,
`ifdef SCOREBOARD_LONG_OP_EN
    input  logic                             long_complete,
    input  logic [REGISTER_NUMBER_WIDTH-1:0] long_destination_register_number,
`endif
    output logic                             stall_a,
    output logic                             stall_b,
    output logic                             stall,
    output logic [REGISTER_COUNT-1:0]        pending
);

    logic [REGISTER_COUNT-1:0] not_ready;
    logic                      issue_fire;
    logic                      waw;

    assign issue_fire = issue_valid & issue_write_enable;

    // Register 0 is hardwired: never pending, never stalls.
    assign pending[0]   = 1'b0;
    assign not_ready[0] = 1'b0;

    for (genvar i = 1; i < REGISTER_COUNT; i++) begin : g_entry
        localparam logic [REGISTER_NUMBER_WIDTH-1:0] Index = REGISTER_NUMBER_WIDTH'(i);

        scoreboard_entry #(
            .LOAD_DELAY (LOAD_DELAY)
        ) u_entry (
            .clock          (clock),
            .reset          (reset),
            .issue          (issue_fire && (issue_destination_register_number == Index)),
            .issue_op_class (issue_op_class),
            .write_back     (write_back_valid
                             && (write_back_destination_register_number == Index)),
            .squash         (squash_valid && (squash_destination_register_number == Index)),
`ifdef SCOREBOARD_LONG_OP_EN
            .long_complete  (long_complete && (long_destination_register_number == Index)),
`endif
            .pending        (pending[i]),
            .not_ready      (not_ready[i])
        );
    end

    always_comb begin
        stall_a = not_ready[register_number_a];
        stall_b = not_ready[register_number_b];
        waw     = decode_write_enable & pending[decode_destination_register_number];
        stall   = stall_a | stall_b | waw;
    end

endmodule

// File: tb/tb_hazard_scoreboard.sv
// Self-checking bench for hazard_scoreboard: per-cycle expectations queued with stimulus.
// Works with or without SCOREBOARD_LONG_OP_EN defined.
module tb_hazard_scoreboard;
    import riscv_pipeline_pkg::*;

`ifdef SCOREBOARD_LONG_OP_EN
    localparam bit LongOn = 1'b1;
`else
    localparam bit LongOn = 1'b0;
`endif

    logic        clock = 1'b0;
    logic        reset;
    logic        issue_valid;
    logic        issue_write_enable;
    logic [4:0]  issue_destination_register_number;
    op_class_t   issue_op_class;
    logic [4:0]  register_number_a;
    logic [4:0]  register_number_b;
    logic [4:0]  decode_destination_register_number;
    logic        decode_write_enable;
    logic        write_back_valid;
    logic [4:0]  write_back_destination_register_number;
    logic        squash_valid;
    logic [4:0]  squash_destination_register_number;
`ifdef SCOREBOARD_LONG_OP_EN
    logic        long_complete;
    logic [4:0]  long_destination_register_number;
`endif
    logic        stall_a;
    logic        stall_b;
    logic        stall;
    logic [31:0] pending;

    typedef struct {
        string       name;
        logic        sa;
        logic        sb;
        logic        st;
        logic [31:0] pend;
    } exp_t;

    exp_t q[$];
    int   checks = 0;
    int   errors = 0;

    always #5 clock = ~clock;

    hazard_scoreboard #(
        .REGISTER_COUNT (32),
        .LOAD_DELAY     (1)
    ) dut (
        .clock                                  (clock),
        .reset                                  (reset),
        .issue_valid                            (issue_valid),
        .issue_write_enable                     (issue_write_enable),
        .issue_destination_register_number      (issue_destination_register_number),
        .issue_op_class                         (issue_op_class),
        .register_number_a                      (register_number_a),
        .register_number_b                      (register_number_b),
        .decode_destination_register_number     (decode_destination_register_number),
        .decode_write_enable                    (decode_write_enable),
        .write_back_valid                       (write_back_valid),
        .write_back_destination_register_number (write_back_destination_register_number),
        .squash_valid                           (squash_valid),
        .squash_destination_register_number     (squash_destination_register_number),
`ifdef SCOREBOARD_LONG_OP_EN
        .long_complete                          (long_complete),
        .long_destination_register_number       (long_destination_register_number),
`endif
        .stall_a                                (stall_a),
        .stall_b                                (stall_b),
        .stall                                  (stall),
        .pending                                (pending)
    );

    task automatic clear_inputs();
        issue_valid                            = 1'b0;
        issue_write_enable                     = 1'b0;
        issue_destination_register_number      = 5'd0;
        issue_op_class                         = OpAlu;
        register_number_a                      = 5'd0;
        register_number_b                      = 5'd0;
        decode_destination_register_number     = 5'd0;
        decode_write_enable                    = 1'b0;
        write_back_valid                       = 1'b0;
        write_back_destination_register_number = 5'd0;
        squash_valid                           = 1'b0;
        squash_destination_register_number     = 5'd0;
`ifdef SCOREBOARD_LONG_OP_EN
        long_complete                          = 1'b0;
        long_destination_register_number       = 5'd0;
`endif
    endtask

    task automatic issue(input logic [4:0] rd, input op_class_t cls);
        issue_valid                       = 1'b1;
        issue_write_enable                = 1'b1;
        issue_destination_register_number = rd;
        issue_op_class                    = cls;
    endtask

    task automatic write_back(input logic [4:0] rd);
        write_back_valid                       = 1'b1;
        write_back_destination_register_number = rd;
    endtask

    task automatic push_exp(input string n, input logic sa, input logic sb, input logic st,
                            input logic [31:0] p);
        exp_t e;
        e.name = n;
        e.sa   = sa;
        e.sb   = sb;
        e.st   = st;
        e.pend = p;
        q.push_back(e);
    endtask

    function automatic logic [31:0] bit_of(input int r);
        return 32'd1 << r;
    endfunction

    task automatic test_reset();
        clear_inputs();
        reset = 1'b1;
        #1;
        checks++;
        if ({stall_a, stall_b, stall, pending} !== 35'd0) begin
            errors++;
            $display("FAIL reset_state: got a=%b b=%b s=%b p=%h, want all 0",
                     stall_a, stall_b, stall, pending);
        end
        repeat (2) @(posedge clock);
        #1;
        reset = 1'b0;
    endtask

    task automatic test_alu();
        exp_t e;
        for (int c = 0; c < 3; c++) begin
            clear_inputs();
            case (c)
                0: begin issue(5'd5, OpAlu); push_exp("alu_issue", 0, 0, 0, 0); end
                1: begin
                    register_number_a = 5'd5;
                    write_back(5'd5);
                    push_exp("alu_dependent", 0, 0, 0, bit_of(5));
                end
                default: begin register_number_a = 5'd5; push_exp("alu_retired", 0, 0, 0, 0); end
            endcase
            @(negedge clock);
            e = q.pop_front();
            checks++;
            if ({stall_a, stall_b, stall, pending} !== {e.sa, e.sb, e.st, e.pend}) begin
                errors++;
                $display("FAIL %s: got a=%b b=%b s=%b p=%h, want a=%b b=%b s=%b p=%h", e.name,
                         stall_a, stall_b, stall, pending, e.sa, e.sb, e.st, e.pend);
            end
            @(posedge clock);
            #1;
        end
    endtask

    task automatic test_load();
        exp_t e;
        for (int c = 0; c < 4; c++) begin
            clear_inputs();
            register_number_b = 5'd7;
            case (c)
                0: begin issue(5'd7, OpLoad); push_exp("load_issue", 0, 0, 0, 0); end
                1: push_exp("load_stall", 0, 1, 1, bit_of(7));
                2: begin write_back(5'd7); push_exp("load_ready", 0, 0, 0, bit_of(7)); end
                default: push_exp("load_retired", 0, 0, 0, 0);
            endcase
            @(negedge clock);
            e = q.pop_front();
            checks++;
            if ({stall_a, stall_b, stall, pending} !== {e.sa, e.sb, e.st, e.pend}) begin
                errors++;
                $display("FAIL %s: got a=%b b=%b s=%b p=%h, want a=%b b=%b s=%b p=%h", e.name,
                         stall_a, stall_b, stall, pending, e.sa, e.sb, e.st, e.pend);
            end
            @(posedge clock);
            #1;
        end
    endtask

    task automatic test_long();
        exp_t e;
        logic st;
        for (int c = 0; c < 10; c++) begin
            clear_inputs();
            register_number_a = 5'd9;
            if (c == 0) begin
                issue(5'd9, OpLong);
                push_exp("long_issue", 0, 0, 0, 0);
            end else if (c <= 6) begin
                // Without long ops the class degrades to LOAD: a single stall cycle.
                st = LongOn ? 1'b1 : (c == 1);
                push_exp("long_wait", st, 0, st, bit_of(9));
            end else if (c == 7) begin
`ifdef SCOREBOARD_LONG_OP_EN
                long_complete                    = 1'b1;
                long_destination_register_number = 5'd9;
`endif
                push_exp("long_complete_cycle", LongOn, 0, LongOn, bit_of(9));
            end else if (c == 8) begin
                write_back(5'd9);
                push_exp("long_released", 0, 0, 0, bit_of(9));
            end else begin
                push_exp("long_retired", 0, 0, 0, 0);
            end
            @(negedge clock);
            e = q.pop_front();
            checks++;
            if ({stall_a, stall_b, stall, pending} !== {e.sa, e.sb, e.st, e.pend}) begin
                errors++;
                $display("FAIL %s cycle %0d: got a=%b b=%b s=%b p=%h, want a=%b b=%b s=%b p=%h",
                         e.name, c, stall_a, stall_b, stall, pending, e.sa, e.sb, e.st, e.pend);
            end
            @(posedge clock);
            #1;
        end
    endtask

    task automatic test_waw();
        exp_t e;
        for (int c = 0; c < 4; c++) begin
            clear_inputs();
            if (c > 0) begin
                decode_write_enable                = 1'b1;
                decode_destination_register_number = 5'd3;
            end
            case (c)
                0: begin issue(5'd3, OpAlu); push_exp("waw_issue", 0, 0, 0, 0); end
                1: push_exp("waw_stall", 0, 0, 1, bit_of(3));
                2: begin write_back(5'd3); push_exp("waw_stall_wb", 0, 0, 1, bit_of(3)); end
                default: push_exp("waw_cleared", 0, 0, 0, 0);
            endcase
            @(negedge clock);
            e = q.pop_front();
            checks++;
            if ({stall_a, stall_b, stall, pending} !== {e.sa, e.sb, e.st, e.pend}) begin
                errors++;
                $display("FAIL %s: got a=%b b=%b s=%b p=%h, want a=%b b=%b s=%b p=%h", e.name,
                         stall_a, stall_b, stall, pending, e.sa, e.sb, e.st, e.pend);
            end
            @(posedge clock);
            #1;
        end
    endtask

    task automatic test_same_cycle_priority();
        exp_t e;
        for (int c = 0; c < 5; c++) begin
            clear_inputs();
            case (c)
                0: begin
                    issue(5'd4, OpAlu);
                    squash_valid                       = 1'b1;
                    squash_destination_register_number = 5'd4;
                    push_exp("squash_and_issue", 0, 0, 0, 0);
                end
                1: begin
                    register_number_a = 5'd4;
                    issue(5'd6, OpLoad);
                    write_back(5'd6);
                    push_exp("squash_wins", 0, 0, 0, 0);
                end
                2: begin
                    register_number_a = 5'd6;
                    push_exp("issue_beats_wb", 1, 0, 1, bit_of(6));
                end
                3: begin
                    register_number_a = 5'd6;
                    write_back(5'd6);
                    push_exp("issue_beats_wb_ready", 0, 0, 0, bit_of(6));
                end
                default: push_exp("priority_retired", 0, 0, 0, 0);
            endcase
            @(negedge clock);
            e = q.pop_front();
            checks++;
            if ({stall_a, stall_b, stall, pending} !== {e.sa, e.sb, e.st, e.pend}) begin
                errors++;
                $display("FAIL %s: got a=%b b=%b s=%b p=%h, want a=%b b=%b s=%b p=%h", e.name,
                         stall_a, stall_b, stall, pending, e.sa, e.sb, e.st, e.pend);
            end
            @(posedge clock);
            #1;
        end
    endtask

    task automatic test_reset_midop();
        exp_t e;
        for (int c = 0; c < 4; c++) begin
            clear_inputs();
            case (c)
                0: begin issue(5'd1, OpAlu); push_exp("midop_issue1", 0, 0, 0, 0); end
                1: begin issue(5'd2, OpLoad); push_exp("midop_issue2", 0, 0, 0, bit_of(1)); end
                2: begin
                    issue(5'd8, OpLong);
                    push_exp("midop_issue8", 0, 0, 0, bit_of(1) | bit_of(2));
                end
                default: begin
                    register_number_a                  = 5'd8;
                    register_number_b                  = 5'd2;
                    decode_write_enable                = 1'b1;
                    decode_destination_register_number = 5'd1;
                    push_exp("midop_busy", 1, 0, 1, bit_of(1) | bit_of(2) | bit_of(8));
                end
            endcase
            @(negedge clock);
            e = q.pop_front();
            checks++;
            if ({stall_a, stall_b, stall, pending} !== {e.sa, e.sb, e.st, e.pend}) begin
                errors++;
                $display("FAIL %s: got a=%b b=%b s=%b p=%h, want a=%b b=%b s=%b p=%h", e.name,
                         stall_a, stall_b, stall, pending, e.sa, e.sb, e.st, e.pend);
            end
            if (c < 3) begin
                @(posedge clock);
                #1;
            end
        end
        // Reset between clock edges while the WAW on x1 would otherwise stall.
        #1;
        reset = 1'b1;
        #1;
        checks++;
        if ({stall_a, stall_b, stall, pending} !== 35'd0) begin
            errors++;
            $display("FAIL reset_immediate: got a=%b b=%b s=%b p=%h, want all 0",
                     stall_a, stall_b, stall, pending);
        end
        issue(5'd1, OpLoad);
        @(posedge clock);
        #1;
        checks++;
        if ({stall_a, stall_b, stall, pending} !== 35'd0) begin
            errors++;
            $display("FAIL reset_hold: got a=%b b=%b s=%b p=%h, want all 0",
                     stall_a, stall_b, stall, pending);
        end
        reset = 1'b0;
        clear_inputs();
    endtask

    task automatic test_register_zero();
        exp_t e;
        for (int c = 0; c < 3; c++) begin
            clear_inputs();
            decode_write_enable                = 1'b1;
            decode_destination_register_number = 5'd0;
            case (c)
                0: begin
                    issue(5'd0, OpLoad);
                    write_back(5'd0);
                    push_exp("x0_issue_load", 0, 0, 0, 0);
                end
                1: begin issue(5'd0, OpLong); push_exp("x0_after_load", 0, 0, 0, 0); end
                default: push_exp("x0_after_long", 0, 0, 0, 0);
            endcase
            @(negedge clock);
            e = q.pop_front();
            checks++;
            if ({stall_a, stall_b, stall, pending} !== {e.sa, e.sb, e.st, e.pend}) begin
                errors++;
                $display("FAIL %s: got a=%b b=%b s=%b p=%h, want a=%b b=%b s=%b p=%h", e.name,
                         stall_a, stall_b, stall, pending, e.sa, e.sb, e.st, e.pend);
            end
            @(posedge clock);
            #1;
        end
    endtask

    initial begin
        test_reset();
        test_alu();
        test_load();
        test_long();
        test_waw();
        test_same_cycle_priority();
        test_reset_midop();
        @(posedge clock);
        #1;
        test_register_zero();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
